// File: rtl/prog_pkg.sv
// Shared codes, step count and state encoding for the RTC programming sequencer.
// Macro PROG_TRIGGER_READ_EN appends the read-launch strobe 5'h1D to the table.
package prog_pkg;

   localparam int IDX_W  = 5;
   localparam int CODE_W = 5;

   typedef logic [CODE_W-1:0] code_t;

   // ctrl_W codes understood by Deco_programar
   localparam code_t C_IDLE       = 5'h00;
   localparam code_t C_REG_FIRST  = 5'h01;
   localparam code_t C_REG_LAST   = 5'h14;
   localparam code_t C_FIN        = 5'h15;
   localparam code_t C_BUS_IDLE   = 5'h16;
   localparam code_t C_BUS_SETUP1 = 5'h17;
   localparam code_t C_BUS_SETUP2 = 5'h1A;
   localparam code_t C_BUS_SETUP3 = 5'h18;
   localparam code_t C_BUS_SETUP4 = 5'h19;
   localparam code_t C_CLOSE1     = 5'h1B;
   localparam code_t C_CLOSE2     = 5'h1C;
   localparam code_t C_INI_E      = 5'h1D;

   // idx range carrying the ascending address/data codes 01..14
   localparam int REG_IDX_FIRST = 5;
   localparam int REG_IDX_LAST  = 24;

`ifdef PROG_TRIGGER_READ_EN
   localparam int PROG_STEPS = 29;
`else
   localparam int PROG_STEPS = 28;
`endif

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/fsm_programar_if.sv
// Handshake bundle between the write sequencer and its requester/observer.
interface fsm_programar_if;
   import prog_pkg::*;

   logic  start_W;
   code_t ctrl_W;
   logic  busy_W;
   logic  done_W;

   modport master (output start_W, input ctrl_W, busy_W, done_W);
   modport slave  (input start_W, output ctrl_W, busy_W, done_W);

endinterface

// File: rtl/prog_step_rom.sv
// Combinational step table: sequence index -> ctrl_W code.
// Entry 28 (5'h1D) exists only when PROG_TRIGGER_READ_EN is defined.
module prog_step_rom
   import prog_pkg::*;
(
   input  logic [IDX_W-1:0] i_idx,
   output code_t            o_code
);

   always_comb begin
      o_code = C_IDLE;
      case (i_idx)
         5'd0:  o_code = C_BUS_IDLE;
         5'd1:  o_code = C_BUS_SETUP1;
         5'd2:  o_code = C_BUS_SETUP2;
         5'd3:  o_code = C_BUS_SETUP3;
         5'd4:  o_code = C_BUS_SETUP4;
         5'd25: o_code = C_CLOSE1;
         5'd26: o_code = C_CLOSE2;
         5'd27: o_code = C_FIN;
`ifdef PROG_TRIGGER_READ_EN
         5'd28: o_code = C_INI_E;
`endif
         default: begin
            // address/data pairs: code = idx - 4, giving 01..14
            if (i_idx >= IDX_W'(REG_IDX_FIRST) && i_idx <= IDX_W'(REG_IDX_LAST))
               o_code = i_idx - IDX_W'(REG_IDX_FIRST - 1);
         end
      endcase
   end

endmodule

// File: rtl/fsm_programar.sv
// RTC write sequencer: steps ctrl_W through the programming table, holding each code
// STEP_CYCLES clocks. Macro PROG_TRIGGER_READ_EN adds the trailing 5'h1D step.
module fsm_programar
   import prog_pkg::*;
#(
   parameter int STEP_CYCLES = 10,
   parameter int CNT_W       = 4
) (
   input  logic            clk,
   input  logic            reset,
   fsm_programar_if.slave  bus
);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(PROG_STEPS - 1);

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx,   w_idx_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic             w_done_nxt;
   code_t            w_rom_code;
   code_t            r_ctrl;
   logic             r_busy;
   logic             r_done;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start_W) begin
               w_state_nxt = RUN;
               w_idx_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (r_cnt == LP_CNT_LAST) begin
               w_cnt_nxt = '0;
               if (r_idx == LP_IDX_LAST) begin
                  w_state_nxt = IDLE;
                  w_idx_nxt   = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Look up the code for the upcoming index so ctrl_W can be registered alongside it
   prog_step_rom u_rom (
      .i_idx  (w_idx_nxt),
      .o_code (w_rom_code)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_ctrl  <= C_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ctrl  <= (w_state_nxt == RUN) ? w_rom_code : C_IDLE;
         r_busy  <= (w_state_nxt == RUN);
         r_done  <= w_done_nxt;
      end
   end

   assign bus.ctrl_W = r_ctrl;
   assign bus.busy_W = r_busy;
   assign bus.done_W = r_done;

endmodule
